// File: rtl/vga_pkg.sv
// Shared types for the VGA transmitter: pixel colour, timing description,
// controller states and the colour-bar lookup used by the test pattern.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [10:0] active;
    logic [7:0]  fp;
    logic [7:0]  sync;
    logic [7:0]  bp;
  } timing_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    c.r = idx[1] ? 8'h00 : 8'hFF;
    c.g = idx[2] ? 8'h00 : 8'hFF;
    c.b = idx[0] ? 8'h00 : 8'hFF;
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with active-area and sync decode.
// Counters restart from (0,0) whenever run is low.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter timing_t H_TIM  = '{active: 11'd640, fp: 8'd16, sync: 8'd96, bp: 8'd48},
  parameter timing_t V_TIM  = '{active: 11'd480, fp: 8'd11, sync: 8'd2,  bp: 8'd31},
  parameter bit      HS_POL = 1'b1,
  parameter bit      VS_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [10:0] hcnt,
  output logic [9:0]  vcnt,
  output logic        active,
  output logic        hs,
  output logic        vs
);

  localparam int HTOT = int'(H_TIM.active) + int'(H_TIM.fp) + int'(H_TIM.sync) + int'(H_TIM.bp);
  localparam int VTOT = int'(V_TIM.active) + int'(V_TIM.fp) + int'(V_TIM.sync) + int'(V_TIM.bp);

  localparam logic [10:0] H_LAST   = 11'(HTOT - 1);
  localparam logic [10:0] H_SYNC_S = 11'(int'(H_TIM.active) + int'(H_TIM.fp));
  localparam logic [10:0] H_SYNC_E = 11'(HTOT - int'(H_TIM.bp));
  localparam logic [9:0]  V_ACT    = 10'(V_TIM.active);
  localparam logic [9:0]  V_LAST   = 10'(VTOT - 1);
  localparam logic [9:0]  V_SYNC_S = 10'(int'(V_TIM.active) + int'(V_TIM.fp));
  localparam logic [9:0]  V_SYNC_E = 10'(VTOT - int'(V_TIM.bp));

  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!run) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
    end else begin
      hcnt_d = hcnt_q + 11'd1;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt   = hcnt_q;
  assign vcnt   = vcnt_q;
  assign active = (hcnt_q < H_TIM.active) && (vcnt_q < V_ACT);
  assign hs     = ((hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E)) ? HS_POL : ~HS_POL;
  assign vs     = ((vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E)) ? VS_POL : ~VS_POL;

endmodule

// File: rtl/vga_tx.sv
// VGA transmitter: locks a pixel stream to the raster on its SOF beat and
// registers rgb/sync/de. Define VGA_TX_TEST_PATTERN_EN for colour-bar output.
module vga_tx
  import vga_pkg::*;
#(
  parameter int HOR_ACT   = 640,
  parameter int HOR_FP    = 16,
  parameter int HOR_SYNC  = 96,
  parameter int HOR_BP    = 48,
  parameter int VERT_ACT  = 480,
  parameter int VERT_FP   = 11,
  parameter int VERT_SYNC = 2,
  parameter int VERT_BP   = 31,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        en,
`ifdef VGA_TX_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_rgb,
  input  logic        s_sof,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        underrun,
  output logic        misalign,
  input  logic        err_clr
);

  localparam timing_t H_TIM = '{active: 11'(HOR_ACT), fp: 8'(HOR_FP), sync: 8'(HOR_SYNC), bp: 8'(HOR_BP)};
  localparam timing_t V_TIM = '{active: 11'(VERT_ACT), fp: 8'(VERT_FP), sync: 8'(VERT_SYNC), bp: 8'(VERT_BP)};

  state_e      state_q, state_d;
  rgb_t        rgb_q, rgb_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        underrun_q, underrun_d;
  logic        misalign_q, misalign_d;

  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        active, hs, vs;
  logic        run, at_origin, take, set_ur, set_ma, ready_c;

`ifdef VGA_TX_TEST_PATTERN_EN
  localparam int BAR_W = HOR_ACT / 8;
  logic [2:0] bar_idx;
  assign bar_idx = 3'(hcnt / 11'(BAR_W));
  // The pattern keeps the raster running even while the FSM sits frozen in IDLE.
  assign run = en && ((state_q != ST_IDLE) || pattern_sel);
`else
  assign run = en && (state_q != ST_IDLE);
`endif

  vga_timing_gen #(
    .H_TIM  (H_TIM),
    .V_TIM  (V_TIM),
    .HS_POL (HSYNC_POL),
    .VS_POL (VSYNC_POL)
  ) u_timing (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .run       (run),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .active    (active),
    .hs        (hs),
    .vs        (vs)
  );

  assign at_origin = (hcnt == 11'd0) && (vcnt == 10'd0);

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    take    = 1'b0;
    set_ur  = 1'b0;
    set_ma  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_SEEK;
      ST_SEEK: begin
        // Non-SOF beats are flushed; an SOF beat waits for the frame origin.
        ready_c = !s_sof || at_origin;
        if (s_valid && s_sof && at_origin) begin
          take    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (active) begin
          ready_c = !(s_sof && !at_origin);
          if (!s_valid) begin
            set_ur  = 1'b1;
            state_d = ST_SEEK;
          end else if (s_sof && !at_origin) begin
            set_ma  = 1'b1;
            state_d = ST_SEEK;
          end else begin
            take = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef VGA_TX_TEST_PATTERN_EN
    if (pattern_sel) begin
      state_d = state_q;
      ready_c = 1'b0;
      take    = 1'b0;
      set_ur  = 1'b0;
      set_ma  = 1'b0;
    end
`endif
    if (!en) begin
      state_d = ST_IDLE;
      ready_c = 1'b0;
      take    = 1'b0;
      set_ur  = 1'b0;
      set_ma  = 1'b0;
    end
  end

  always_comb begin
    rgb_d = take ? rgb_t'(s_rgb) : '0;
`ifdef VGA_TX_TEST_PATTERN_EN
    if (run && pattern_sel && active) rgb_d = bar_color(bar_idx);
`endif
    de_d       = run && active;
    hsync_d    = run ? hs : ~HSYNC_POL;
    vsync_d    = run ? vs : ~VSYNC_POL;
    underrun_d = set_ur ? 1'b1 : (err_clr ? 1'b0 : underrun_q);
    misalign_d = set_ma ? 1'b1 : (err_clr ? 1'b0 : misalign_q);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rgb_q      <= '0;
      de_q       <= 1'b0;
      hsync_q    <= ~HSYNC_POL;
      vsync_q    <= ~VSYNC_POL;
      underrun_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= en ? state_d : ST_IDLE;
      rgb_q      <= rgb_d;
      de_q       <= de_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      underrun_q <= underrun_d;
      misalign_q <= misalign_d;
    end
  end

  assign s_ready  = ready_c;
  assign r        = rgb_q.r;
  assign g        = rgb_q.g;
  assign b        = rgb_q.b;
  assign de       = de_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign underrun = underrun_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_vga_tx.sv
// Directed bench for vga_tx on a 15x8 raster (HOR 8/2/3/2, VERT 4/1/2/1).
module tb_vga_tx;

  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        en        = 1'b0;
  logic        s_valid   = 1'b0;
  logic        s_sof     = 1'b0;
  logic        err_clr   = 1'b0;
  logic [23:0] s_rgb     = '0;
  logic        s_ready;
  logic [7:0]  r, g, b;
  logic        hsync, vsync, de, underrun, misalign;
  logic [23:0] rgb_o;
`ifdef VGA_TX_TEST_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [23:0] HELD = 24'hABCDEF;

  always #5 pixel_clk = ~pixel_clk;

  assign rgb_o = {r, g, b};

  vga_tx #(
    .HOR_ACT(8), .HOR_FP(2), .HOR_SYNC(3), .HOR_BP(2),
    .VERT_ACT(4), .VERT_FP(1), .VERT_SYNC(2), .VERT_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .en        (en),
`ifdef VGA_TX_TEST_PATTERN_EN
    .pattern_sel (pattern_sel),
`endif
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_rgb     (s_rgb),
    .s_sof     (s_sof),
    .r         (r),
    .g         (g),
    .b         (b),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .underrun  (underrun),
    .misalign  (misalign),
    .err_clr   (err_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  // One full 120-cycle frame starting at counter (0,0). Active pixel k carries
  // base+k (pixel 0 carries first, with SOF). drop_c removes a beat, mis_c
  // raises SOF early and holds that beat to the end, clr_c pulses err_clr.
  task automatic frame(input string tag, input logic [23:0] base, input logic [23:0] first,
                       input int drop_c, input int mis_c, input int clr_c);
    logic        held;
    logic        act;
    logic [23:0] exp;
    int          h, v, k;
    held = 1'b0;
    for (int c = 0; c < 120; c++) begin
      h   = c % 15;
      v   = c / 15;
      act = (h < 8) && (v < 4);
      k   = v * 8 + h;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_rgb   = '0;
      err_clr = (c == clr_c);
      if (held || c == mis_c) begin
        held    = 1'b1;
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_rgb   = HELD;
      end else if (act) begin
        s_valid = (c != drop_c);
        s_sof   = (k == 0);
        s_rgb   = (k == 0) ? first : base + 24'(k);
      end
      exp = '0;
      if (act && !(drop_c >= 0 && c >= drop_c) && !(mis_c >= 0 && c >= mis_c))
        exp = (k == 0) ? first : base + 24'(k);
      #1;
      if (c == mis_c) check_eq({tag, "_rdy_mis"}, s_ready, 0);
      if (drop_c >= 0 && c == drop_c + 1) check_eq({tag, "_rdy_drop"}, s_ready, 1);
      tick();
      check_eq({tag, "_rgb"}, rgb_o, exp);
      check_eq({tag, "_de"}, de, act);
      if (c == drop_c) check_eq({tag, "_underrun"}, underrun, 1);
      if (c == mis_c) check_eq({tag, "_misalign"}, misalign, 1);
    end
    err_clr = 1'b0;
  endtask

  initial begin
    int h, v, de_cnt;
    logic act;

    repeat (3) tick();
    check_eq("rst_hsync", hsync, 0);
    check_eq("rst_vsync", vsync, 0);
    check_eq("rst_de", de, 0);
    check_eq("rst_rgb", rgb_o, 0);
    check_eq("rst_ready", s_ready, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_misalign", misalign, 0);
    check_eq("rst_hcnt", dut.hcnt, 0);

    rst_n = 1'b1;
    tick();
    en = 1'b1;
    tick();
    check_eq("seek_entry_de", de, 0);
    check_eq("seek_entry_hsync", hsync, 0);
    check_eq("seek_entry_hcnt", dut.hcnt, 0);

    // Free-running raster with no stream.
    de_cnt = 0;
    for (int c = 0; c < 120; c++) begin
      h   = c % 15;
      v   = c / 15;
      act = (h < 8) && (v < 4);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      #1;
      if (c == 0) check_eq("seek_ready_nosof", s_ready, 1);
      tick();
      check_eq("idle_hsync", hsync, (h >= 10 && h <= 12));
      check_eq("idle_vsync", vsync, (v >= 5 && v <= 6));
      check_eq("idle_de", de, act);
      check_eq("idle_rgb", rgb_o, 0);
      if (de) de_cnt++;
      if (c == 20) begin
        check_eq("mid_hcnt", dut.hcnt, 6);
        check_eq("mid_vcnt", dut.vcnt, 1);
      end
    end
    check_eq("de_per_frame", de_cnt, 32);
    check_eq("wrap_hcnt", dut.hcnt, 0);
    check_eq("wrap_vcnt", dut.vcnt, 0);

    frame("strmA", 24'h000001, 24'h000001, -1, -1, -1);
    check_eq("strmA_underrun", underrun, 0);
    check_eq("strmA_misalign", misalign, 0);

    frame("dropB", 24'h000100, 24'h000100, 35, -1, -1);
    frame("realC", 24'h000200, 24'h000200, -1, -1, -1);
    check_eq("realC_underrun_sticky", underrun, 1);

    frame("clrD", 24'h000300, 24'h000300, -1, -1, 100);
    check_eq("clrD_underrun", underrun, 0);

    frame("misE", 24'h000400, 24'h000400, -1, 18, -1);
    frame("heldF", 24'h000500, HELD, -1, -1, -1);
    check_eq("heldF_misalign_sticky", misalign, 1);

    frame("setwinG", 24'h000600, 24'h000600, 35, -1, 35);
    check_eq("setwinG_underrun", underrun, 1);
    check_eq("setwinG_misalign", misalign, 0);

    // Drop enable while both syncs are asserted.
    for (int c = 0; c < 86; c++) begin
      s_valid = 1'b0;
      s_sof   = 1'b0;
      tick();
      if (c == 85) begin
        check_eq("pre_off_hsync", hsync, 1);
        check_eq("pre_off_vsync", vsync, 1);
      end
    end
    en = 1'b0;
    tick();
    check_eq("off_hsync", hsync, 0);
    check_eq("off_vsync", vsync, 0);
    check_eq("off_de", de, 0);
    check_eq("off_hcnt", dut.hcnt, 0);
    check_eq("off_vcnt", dut.vcnt, 0);
    check_eq("off_underrun_kept", underrun, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("clr_underrun", underrun, 0);
    check_eq("clr_misalign", misalign, 0);

    // Asynchronous reset in the middle of a sync pulse with an SOF beat held.
    en = 1'b1;
    tick();
    repeat (12) tick();
    check_eq("pre_rst_hsync", hsync, 1);
    s_valid = 1'b1;
    s_sof   = 1'b1;
    s_rgb   = HELD;
    #1;
    check_eq("held_ready", s_ready, 0);
    rst_n = 1'b0;
    #1;
    check_eq("arst_hsync", hsync, 0);
    check_eq("arst_hcnt", dut.hcnt, 0);
    check_eq("arst_ready", s_ready, 0);
    check_eq("arst_de", de, 0);
    #1;
    rst_n = 1'b1;
    tick();
    check_eq("relock_ready", s_ready, 1);
    tick();
    check_eq("relock_rgb", rgb_o, HELD);

`ifdef VGA_TX_TEST_PATTERN_EN
    rst_n = 1'b0;
    en    = 1'b0;
    s_sof = 1'b0;
    pattern_sel = 1'b1;
    tick();
    rst_n = 1'b1;
    en    = 1'b1;
    #1;
    check_eq("pat_ready0", s_ready, 0);
    tick();
    check_eq("pat_x0", rgb_o, 24'hFFFFFF);
    tick();
    check_eq("pat_x1", rgb_o, 24'hFFFF00);
    repeat (6) tick();
    check_eq("pat_x7", rgb_o, 24'h000000);
    check_eq("pat_ready7", s_ready, 0);
    check_eq("pat_underrun", underrun, 0);
    check_eq("pat_misalign", misalign, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
